// File: rtl/mbt_scan_ctrl.sv
// Frame-scan sequencer: walks LANES-wide pixel groups across the frame, launching the MBT lanes per group.
// Optional watchdog on the RUN wait is enabled by defining MBT_WATCHDOG_EN.
module mbt_scan_ctrl #(
    parameter int N         = 16,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int LANES     = 4,
    parameter int FETCH_LAT = 3,
    parameter int WD_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [N-1:0]     x_min_in,
    input  logic [N-1:0]     y_max_in,
    input  logic [1:0]       zoom_in,
    output logic [N-1:0]     x_min,
    output logic [N-1:0]     y_max,
    output logic [1:0]       zoom_level,
    output logic [15:0]      i_x,
    output logic [15:0]      i_y,
    output logic             rstMBT,
    output logic             start,
    input  logic [LANES-1:0] mbt_done,
    output logic             wr_req,
    output logic [15:0]      wr_x,
    output logic [15:0]      wr_y,
    input  logic             wr_ack,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_flag,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_RUN     = 3'd3,
        S_WRITE   = 3'd4,
        S_ADVANCE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [7:0]  SETUP_LAST = 8'(FETCH_LAT - 1);
    localparam logic [15:0] STEP_X     = 16'(LANES);
    localparam logic [15:0] END_X      = 16'(H_RES);
    localparam logic [15:0] LAST_X     = 16'(H_RES - LANES);
    localparam logic [15:0] LAST_Y     = 16'(V_RES - 1);

    state_t           state, state_nxt;
    logic [7:0]       setup_cnt;
    logic [LANES-1:0] done_mask;
    logic             mask_all;
    logic             wd_hit;
    logic             last_group;

    assign mask_all   = &(done_mask | mbt_done);
    assign last_group = (i_x == LAST_X) && (i_y == LAST_Y);
    assign dbg_state  = state;
    assign wr_x       = i_x;
    assign wr_y       = i_y;

`ifdef MBT_WATCHDOG_EN
    // Trip one cycle early so WRITE lands exactly WD_CYCLES cycles after LAUNCH.
    localparam logic [15:0] WD_TRIP = 16'(WD_CYCLES - 2);
    logic [15:0] wd_cnt;
    logic        timeout_q;

    assign wd_hit       = (state == S_RUN) && !mask_all && (wd_cnt == WD_TRIP);
    assign timeout_flag = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_IDLE && frame_start)
                timeout_q <= 1'b0;
            else if (wd_hit)
                timeout_q <= 1'b1;
            if (state == S_LAUNCH)
                wd_cnt <= '0;
            else if (state == S_RUN)
                wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign wd_hit       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (frame_start) state_nxt = S_SETUP;
            S_SETUP:   if (setup_cnt == SETUP_LAST) state_nxt = S_LAUNCH;
            S_LAUNCH:  state_nxt = S_RUN;
            S_RUN:     if (mask_all || wd_hit) state_nxt = S_WRITE;
            S_WRITE:   if (wr_ack) state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = last_group ? S_DONE : S_SETUP;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // wr_req/wr_ack: wr_req holds with wr_x/wr_y stable until the cycle wr_ack is sampled high.
    always_comb begin
        rstMBT     = 1'b0;
        start      = 1'b0;
        wr_req     = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_SETUP:  rstMBT     = 1'b1;
            S_LAUNCH: start      = 1'b1;
            S_WRITE:  wr_req     = 1'b1;
            S_DONE:   frame_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min      <= '0;
            y_max      <= '0;
            zoom_level <= '0;
            i_x        <= '0;
            i_y        <= '0;
            setup_cnt  <= '0;
            done_mask  <= '0;
        end else begin
            setup_cnt <= (state == S_SETUP) ? setup_cnt + 8'd1 : 8'd0;
            case (state)
                S_IDLE: if (frame_start) begin
                    x_min      <= x_min_in;
                    y_max      <= y_max_in;
                    zoom_level <= zoom_in;
                    i_x        <= '0;
                    i_y        <= '0;
                end
                S_LAUNCH: done_mask <= '0;
                // Lane flags seen before LAUNCH never reach the mask.
                S_RUN: done_mask <= wd_hit ? '1 : (done_mask | mbt_done);
                S_ADVANCE: begin
                    if (i_x + STEP_X < END_X) begin
                        i_x <= i_x + STEP_X;
                    end else begin
                        i_x <= '0;
                        i_y <= i_y + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mbt_scan_ctrl.sv
// Directed bench for mbt_scan_ctrl on an 8x2 frame: group order, launch timing, backpressure, reset, watchdog.
module tb_mbt_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] x_min_in = '0, y_max_in = '0;
    logic [1:0]  zoom_in = '0;
    logic [15:0] x_min, y_max, i_x, i_y, wr_x, wr_y;
    logic [1:0]  zoom_level;
    logic        rstMBT, start, wr_req, busy, frame_done, timeout_flag;
    logic [3:0]  mbt_done = '0;
    logic        wr_ack = 1'b0;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    mbt_scan_ctrl #(
        .N(16), .H_RES(8), .V_RES(2), .LANES(4), .FETCH_LAT(3), .WD_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x_min_in(x_min_in), .y_max_in(y_max_in), .zoom_in(zoom_in),
        .x_min(x_min), .y_max(y_max), .zoom_level(zoom_level),
        .i_x(i_x), .i_y(i_y), .rstMBT(rstMBT), .start(start),
        .mbt_done(mbt_done), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
        .wr_ack(wr_ack), .busy(busy), .frame_done(frame_done),
        .timeout_flag(timeout_flag), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=stalled expected=finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Enters at the first SETUP cycle of a group and leaves at the cycle after ADVANCE.
    task automatic do_group(input logic [15:0] ex, input logic [15:0] ey,
                            input int l0, input int l1, input int l2, input int l3,
                            input bit spurious, input int bp, input bit poke_start);
        int lat[4];
        int mx;
        int n_rst;
        bit stable;
        logic [3:0] bits;
        lat = '{l0, l1, l2, l3};
        mx = 0;
        for (int i = 0; i < 4; i++) if (lat[i] > mx) mx = lat[i];
        n_rst = 0;
        while (rstMBT === 1'b1 && n_rst < 20) begin
            mbt_done = (spurious && n_rst == 1) ? 4'b1111 : 4'b0000;
            n_rst++;
            tick();
        end
        mbt_done = '0;
        chk("setup_len", n_rst, 3);
        chk("start_hi", start, 1'b1);
        chk("group_x", i_x, ex);
        chk("group_y", i_y, ey);
        if (poke_start) begin
            frame_start = 1'b1;
            x_min_in = 16'h0000;
        end
        for (int c = 1; c <= mx; c++) begin
            tick();
            frame_start = 1'b0;
            bits = '0;
            for (int i = 0; i < 4; i++) if (lat[i] == c) bits[i] = 1'b1;
            mbt_done = bits;
            if (c == 1) chk("start_pulse", start, 1'b0);
            if (c == mx) chk("wr_req_early", wr_req, 1'b0);
        end
        tick();
        mbt_done = '0;
        chk("wr_req", wr_req, 1'b1);
        chk("wr_x", wr_x, ex);
        chk("wr_y", wr_y, ey);
        stable = 1'b1;
        for (int b = 0; b < bp; b++) begin
            wr_ack = 1'b0;
            tick();
            if (!(wr_req === 1'b1 && wr_x === ex && wr_y === ey && i_x === ex && i_y === ey))
                stable = 1'b0;
        end
        if (bp > 0) chk("bp_stable", stable, 1'b1);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("adv_state", dbg_state, 3'd5);
        chk("x_min_hold", x_min, 16'hf800);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", dbg_state, 3'd0);
        chk("rst_outs", {rstMBT, start, wr_req, frame_done, timeout_flag}, 5'b0);
        rst_n = 1'b1;
        tick();

        // Frame 1: full 8x2 scan
        x_min_in = 16'hf800; y_max_in = 16'h1000; zoom_in = 2'd2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        x_min_in = 16'h1234;
        chk("lat_x_min", x_min, 16'hf800);
        chk("lat_y_max", y_max, 16'h1000);
        chk("lat_zoom", zoom_level, 2'd2);
        chk("busy_on", busy, 1'b1);

        do_group(16'd0, 16'd0, 5, 5, 5, 5, 1'b0, 0, 1'b0);
        do_group(16'd4, 16'd0, 2, 9, 4, 7, 1'b1, 0, 1'b0);
        do_group(16'd0, 16'd1, 5, 5, 5, 5, 1'b0, 10, 1'b0);
        do_group(16'd4, 16'd1, 5, 5, 5, 5, 1'b0, 0, 1'b1);

        chk("frame_done_hi", frame_done, 1'b1);
        chk("busy_in_done", busy, 1'b1);
        x_min_in = 16'h0aaa;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("done_to_idle", dbg_state, 3'd0);
        chk("busy_off", busy, 1'b0);
        chk("frame_done_cnt", fd_cnt, 1);
`ifndef MBT_WATCHDOG_EN
        chk("no_timeout", timeout_flag, 1'b0);
`endif

        // Frame 2: abandoned by reset mid-RUN
        x_min_in = 16'h0abc;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_run", dbg_state, 3'd3);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_state", dbg_state, 3'd0);
        chk("mid_rst_outs", {busy, rstMBT, start, wr_req, frame_done}, 5'b0);
        chk("mid_rst_view", {x_min, i_x, i_y}, 48'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("no_frame_done", fd_cnt, 1);
        chk("idle_after_rst", wr_req, 1'b0);

`ifdef MBT_WATCHDOG_EN
        // Frame 3: lane 2 never reports
        x_min_in = 16'hf800;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("wd_launch", start, 1'b1);
        mbt_done = 4'b1011;
        for (int k = 1; k < 16; k++) tick();
        chk("wd_not_yet", wr_req, 1'b0);
        tick();
        chk("wd_write", wr_req, 1'b1);
        chk("wd_flag", timeout_flag, 1'b1);
        mbt_done = '0;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        tick();
        chk("wd_sticky", timeout_flag, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("wd_rst_clear", timeout_flag, 1'b0);
        rst_n = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
